// File: rtl/i2c_target_fsm.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// i2c_target_fsm
//
// I2C target (slave) controller. SCL and SDA are oversampled on clk. The
// block detects START, repeated START and STOP, and matches a 7-bit address.
// On a write it receives bytes and hands each one to the user. On a read it
// asks the user for bytes and shifts them out. SDA is open-drain: the block
// only pulls the line low (sda_oe=1) or releases it (sda_oe=0).
//
// Ports
//   clk       system clock. The SCL low and high phases must each last
//             at least 6 clk.
//   rst_n     asynchronous, active-low reset
//   scl_in    raw SCL pad input (asynchronous)
//   sda_in    raw SDA pad input (asynchronous)
//   sda_oe    1 = pull SDA low, 0 = release
//   tx_data   byte to transmit on a read. Must be valid from the tx_req pulse
//             until the following SCL fall.
//   tx_req    one-clk pulse: tx_data is consumed at the next SCL fall
//   rx_ready  1 = ACK the byte being received, 0 = NACK it
//   rx_data   last received byte
//   rx_valid  one-clk pulse when rx_data updates
//   addr_hit  high from the address ACK until the next STOP or START
//   busy      high from START until STOP
//   state     current FSM state (debug)
//
// Handshake: tx_req and rx_valid are single-cycle strobes with no
// back-pressure. For tx, the user presents tx_data in response to tx_req and
// holds it until the byte is loaded at the next SCL fall. For rx, the user
// captures rx_data on the rx_valid cycle and chooses ACK/NACK through
// rx_ready. rx_ready is sampled at the SCL fall that opens the ACK slot.
// ---------------------------------------------------------------------------
module i2c_target_fsm #(
    parameter int                  ADDR_LEN    = 7,
    parameter int                  DATA_LEN    = 8,
    parameter logic [ADDR_LEN-1:0] TARGET_ADDR = 7'h50
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                scl_in,
    input  logic                sda_in,
    output logic                sda_oe,
    input  logic [DATA_LEN-1:0] tx_data,
    output logic                tx_req,
    input  logic                rx_ready,
    output logic [DATA_LEN-1:0] rx_data,
    output logic                rx_valid,
    output logic                addr_hit,
    output logic                busy,
    output logic [2:0]          state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        RX_DATA  = 3'd3,
        RX_ACK   = 3'd4,
        TX_DATA  = 3'd5,
        TX_ACK   = 3'd6
    } state_t;

    // The address phase carries the address bits plus the R/W bit.
    localparam logic [3:0] ADDR_BITS = 4'(ADDR_LEN + 1);
    localparam logic [3:0] BYTE_BITS = 4'(DATA_LEN);

    // -----------------------------------------------------------------------
    // Input synchronizers plus one history register per line.
    // These reset to 1 (idle bus), so leaving reset never fakes a START.
    // -----------------------------------------------------------------------
    logic scl_s1, scl_s2, scl_d;
    logic sda_s1, sda_s2, sda_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_d  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_s1 <= scl_in;
            scl_s2 <= scl_s1;
            scl_d  <= scl_s2;
            sda_s1 <= sda_in;
            sda_s2 <= sda_s1;
            sda_d  <= sda_s2;
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det;

    assign scl_rise = scl_s2 & ~scl_d;
    assign scl_fall = ~scl_s2 & scl_d;
    // SCL must be high in both samples. An SDA change in the same clk as an
    // SCL change therefore counts only as an SCL edge.
    assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
    assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [3:0]          bit_cnt_q, bit_cnt_d;
    logic [DATA_LEN-1:0] shift_q, shift_d;
    logic                sda_oe_q, sda_oe_d;
    logic                tx_req_q, tx_req_d;
    logic [DATA_LEN-1:0] rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                addr_hit_q, addr_hit_d;
    logic                busy_q, busy_d;
    logic                mack_q, mack_d;   // controller ACKed the last tx byte

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            sda_oe_q   <= 1'b0;
            tx_req_q   <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            addr_hit_q <= 1'b0;
            busy_q     <= 1'b0;
            mack_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            sda_oe_q   <= sda_oe_d;
            tx_req_q   <= tx_req_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            addr_hit_q <= addr_hit_d;
            busy_q     <= busy_d;
            mack_q     <= mack_d;
        end
    end

    // Address bits sit above the R/W bit once the address phase completes.
    logic                addr_match;
    logic                rw_bit;
    logic [DATA_LEN-1:0] shift_in;

    assign addr_match = (shift_q[ADDR_LEN:1] == TARGET_ADDR);
    assign rw_bit     = shift_q[0];
    assign shift_in   = {shift_q[DATA_LEN-2:0], sda_s2};

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        sda_oe_d   = sda_oe_q;
        tx_req_d   = 1'b0;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        addr_hit_d = addr_hit_q;
        busy_d     = busy_q;
        mack_d     = mack_q;

        if (start_det) begin
            // Covers both START and repeated START. A byte in progress is
            // abandoned, and SDA is released.
            state_d    = ADDR;
            busy_d     = 1'b1;
            bit_cnt_d  = '0;
            sda_oe_d   = 1'b0;
            addr_hit_d = 1'b0;
        end else if (stop_det) begin
            state_d    = IDLE;
            busy_d     = 1'b0;
            sda_oe_d   = 1'b0;
            addr_hit_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                end

                ADDR: begin
                    if (scl_rise && bit_cnt_q < ADDR_BITS) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == ADDR_BITS) begin
                        if (addr_match) begin
                            state_d    = ADDR_ACK;
                            sda_oe_d   = 1'b1;
                            addr_hit_d = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end

                ADDR_ACK: begin
                    // For a read, ask for the first byte early. It is loaded
                    // when the ACK clock ends.
                    if (scl_rise && rw_bit) begin
                        tx_req_d = 1'b1;
                    end else if (scl_fall) begin
                        bit_cnt_d = '0;
                        if (rw_bit) begin
                            state_d  = TX_DATA;
                            shift_d  = tx_data;
                            sda_oe_d = ~tx_data[DATA_LEN-1];
                        end else begin
                            state_d  = RX_DATA;
                            sda_oe_d = 1'b0;
                        end
                    end
                end

                RX_DATA: begin
                    if (scl_rise && bit_cnt_q < BYTE_BITS) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == BYTE_BITS - 4'd1) begin
                            rx_data_d  = shift_in;
                            rx_valid_d = 1'b1;
                        end
                    end else if (scl_fall && bit_cnt_q == BYTE_BITS) begin
                        state_d  = RX_ACK;
                        sda_oe_d = rx_ready;
                    end
                end

                RX_ACK: begin
                    // sda_oe_q still holds the ACK/NACK decision for this slot.
                    if (scl_fall) begin
                        if (sda_oe_q) begin
                            state_d   = RX_DATA;
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end

                TX_DATA: begin
                    // The MSB is already driven on entry. Each later fall
                    // presents the next bit. The fall after bit 8 opens the
                    // controller's ACK slot.
                    if (scl_rise && bit_cnt_q < BYTE_BITS) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q != 4'd0) begin
                        if (bit_cnt_q < BYTE_BITS) begin
                            shift_d  = {shift_q[DATA_LEN-2:0], 1'b0};
                            sda_oe_d = ~shift_q[DATA_LEN-2];
                        end else begin
                            state_d  = TX_ACK;
                            sda_oe_d = 1'b0;
                        end
                    end
                end

                TX_ACK: begin
                    if (scl_rise) begin
                        mack_d   = ~sda_s2;
                        tx_req_d = ~sda_s2;
                    end else if (scl_fall) begin
                        if (mack_q) begin
                            state_d   = TX_DATA;
                            shift_d   = tx_data;
                            sda_oe_d  = ~tx_data[DATA_LEN-1];
                            bit_cnt_d = '0;
                        end else begin
                            state_d  = IDLE;
                            sda_oe_d = 1'b0;
                        end
                    end
                end

                default: begin
                    state_d  = IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    assign sda_oe   = sda_oe_q;
    assign tx_req   = tx_req_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign addr_hit = addr_hit_q;
    assign busy     = busy_q;
    assign state    = state_q;

endmodule

// File: tb/tb_i2c_target_fsm.sv
`timescale 1ns/1ps
module tb_i2c_target_fsm;

  // ---------------- clock / reset / bus ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl_m = 1'b1;       // controller SCL drive
  logic sda_m = 1'b1;       // controller SDA drive (1 = released)
  logic rx_ready = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic sda_oe, tx_req, rx_valid, addr_hit, busy;
  logic [7:0] rx_data;
  logic [2:0] state;
  wire sda_line;

  assign sda_line = sda_m & ~sda_oe;   // wired-AND open-drain bus

  always #5 clk = ~clk;

  i2c_target_fsm #(.ADDR_LEN(7), .DATA_LEN(8), .TARGET_ADDR(7'h50)) dut (
    .clk(clk), .rst_n(rst_n), .scl_in(scl_m), .sda_in(sda_line),
    .sda_oe(sda_oe), .tx_data(tx_data), .tx_req(tx_req),
    .rx_ready(rx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .addr_hit(addr_hit), .busy(busy), .state(state)
  );

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];      // expected rx bytes
  logic [7:0] tx_exp_q[$];   // expected bytes seen on SDA during reads
  logic [7:0] rx_got[64];
  int rx_cnt = 0;            // written by monitor only
  int rx_rd = 0;             // written by main only
  logic [7:0] tx_src[16];
  int tx_wr = 0;             // written by main only
  int tx_sent = 0;           // written by monitor only
  int tx_req_cnt = 0;
  int oe_cnt = 0;

  // Output monitor, sampled on the inactive clock edge.
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_got[rx_cnt[5:0]] = rx_data;
      rx_cnt = rx_cnt + 1;
    end
    if (sda_oe) oe_cnt = oe_cnt + 1;
    if (tx_req) begin
      tx_req_cnt = tx_req_cnt + 1;
      if (tx_sent < tx_wr) begin
        tx_data = tx_src[tx_sent[3:0]];
        tx_sent = tx_sent + 1;
      end
    end
  end

  // ---------------- check helpers ----------------
  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drain_rx(input string name);
    chki({name, "_rx_count"}, rx_cnt - rx_rd, exp_q.size());
    while (rx_rd < rx_cnt && exp_q.size() > 0) begin
      chk8({name, "_rx_data"}, rx_got[rx_rd[5:0]], exp_q.pop_front());
      rx_rd++;
    end
    rx_rd = rx_cnt;
    exp_q.delete();
  endtask

  task automatic queue_tx(input logic [7:0] b);
    tx_src[tx_wr[3:0]] = b;
    tx_wr++;
    tx_exp_q.push_back(b);
  endtask

  task automatic check_reset_values(input string name);
    chk1({name, "_sda_oe"}, sda_oe, 1'b0);
    chk1({name, "_tx_req"}, tx_req, 1'b0);
    chk8({name, "_rx_data"}, rx_data, 8'h00);
    chk1({name, "_rx_valid"}, rx_valid, 1'b0);
    chk1({name, "_addr_hit"}, addr_hit, 1'b0);
    chk1({name, "_busy"}, busy, 1'b0);
    chk8({name, "_state"}, 8'(state), 8'd0);
  endtask

  // ---------------- bus driver tasks ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Ends 4 clk into SCL low.
  task automatic i2c_start();
    if (scl_m == 1'b0) begin
      sda_m = 1'b1;
      wait_clk(4);
      scl_m = 1'b1;
      wait_clk(8);
    end
    sda_m = 1'b0;
    wait_clk(8);
    scl_m = 1'b0;
    wait_clk(4);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    wait_clk(4);
    scl_m = 1'b1;
    wait_clk(8);
    sda_m = 1'b1;
    wait_clk(8);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;
    wait_clk(4);
    scl_m = 1'b1;
    wait_clk(8);
    scl_m = 1'b0;
    wait_clk(4);
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1;
    wait_clk(4);
    scl_m = 1'b1;
    wait_clk(4);
    b = sda_line;
    wait_clk(4);
    scl_m = 1'b0;
    wait_clk(4);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic bv;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    recv_bit(bv);
    ack = ~bv;
  endtask

  task automatic recv_byte(output logic [7:0] b, input logic mack);
    logic bv;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      recv_bit(bv);
      b = {b[6:0], bv};
    end
    send_bit(~mack);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] addr_byte;
    logic [7:0] data;
    logic       rx_rdy;
    logic       exp_addr_ack;
    logic       exp_data_ack;
    logic [2:0] exp_state;     // state after the data byte's ACK slot
  } wr_vec_t;

  wr_vec_t vecs[6];

  initial begin
    logic ack;
    logic [7:0] b;
    int base_oe;
    int base_req;

    vecs[0] = '{8'hA0, 8'h5A, 1'b1, 1'b1, 1'b1, 3'd3};
    vecs[1] = '{8'hA0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd3};
    vecs[2] = '{8'hA0, 8'hFF, 1'b0, 1'b1, 1'b0, 3'd0};
    vecs[3] = '{8'hA4, 8'h3C, 1'b1, 1'b0, 1'b0, 3'd0};
    vecs[4] = '{8'hA2, 8'h3C, 1'b1, 1'b0, 1'b0, 3'd0};
    vecs[5] = '{8'h20, 8'h81, 1'b1, 1'b0, 1'b0, 3'd0};

    // reset state
    wait_clk(3);
    check_reset_values("reset");
    rst_n = 1'b1;
    wait_clk(4);

    // table-driven single-byte writes
    foreach (vecs[i]) begin
      rx_ready = vecs[i].rx_rdy;
      if (vecs[i].exp_addr_ack) exp_q.push_back(vecs[i].data);
      base_oe = oe_cnt;
      i2c_start();
      chk1("vec_busy_after_start", busy, 1'b1);
      send_byte(vecs[i].addr_byte, ack);
      chk1("vec_addr_ack", ack, vecs[i].exp_addr_ack);
      chk1("vec_addr_hit", addr_hit, vecs[i].exp_addr_ack);
      send_byte(vecs[i].data, ack);
      chk1("vec_data_ack", ack, vecs[i].exp_data_ack);
      chk8("vec_state", 8'(state), 8'(vecs[i].exp_state));
      if (!vecs[i].exp_addr_ack) chki("vec_no_sda_drive", oe_cnt - base_oe, 0);
      i2c_stop();
      chk1("vec_busy_after_stop", busy, 1'b0);
      chk8("vec_state_after_stop", 8'(state), 8'd0);
      drain_rx("vec");
    end
    rx_ready = 1'b1;

    // two-byte write
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    i2c_start();
    send_byte(8'hA0, ack);
    chk1("wr2_addr_ack", ack, 1'b1);
    send_byte(8'h3C, ack);
    chk1("wr2_ack0", ack, 1'b1);
    send_byte(8'hC3, ack);
    chk1("wr2_ack1", ack, 1'b1);
    chk1("wr2_busy", busy, 1'b1);
    i2c_stop();
    chk1("wr2_busy_after_stop", busy, 1'b0);
    drain_rx("wr2");

    // NACKed byte, then following byte ignored
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    i2c_start();
    send_byte(8'hA0, ack);
    chk1("nack_addr_ack", ack, 1'b1);
    send_byte(8'h11, ack);
    chk1("nack_data_ack", ack, 1'b0);
    chk8("nack_state", 8'(state), 8'd0);
    base_oe = oe_cnt;
    send_byte(8'h22, ack);
    chk1("nack_ignored_ack", ack, 1'b0);
    chki("nack_ignored_no_drive", oe_cnt - base_oe, 0);
    i2c_stop();
    drain_rx("nack");
    rx_ready = 1'b1;

    // read two bytes, ACK then NACK
    queue_tx(8'hA5);
    queue_tx(8'h5A);
    base_req = tx_req_cnt;
    i2c_start();
    send_byte(8'hA1, ack);
    chk1("rd_addr_ack", ack, 1'b1);
    recv_byte(b, 1'b1);
    chk8("rd_byte0", b, tx_exp_q.pop_front());
    recv_byte(b, 1'b0);
    chk8("rd_byte1", b, tx_exp_q.pop_front());
    chki("rd_tx_req_count", tx_req_cnt - base_req, 2);
    chk1("rd_sda_released", sda_oe, 1'b0);
    chk8("rd_state", 8'(state), 8'd0);
    i2c_stop();
    chk1("rd_busy_after_stop", busy, 1'b0);
    drain_rx("rd");

    // partial write byte aborted by repeated START, then read
    i2c_start();
    send_byte(8'hA0, ack);
    chk1("rs_addr_ack", ack, 1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    i2c_start();
    chk8("rs_state", 8'(state), 8'd1);
    chk1("rs_addr_hit", addr_hit, 1'b0);
    chk1("rs_sda_oe", sda_oe, 1'b0);
    chk1("rs_busy", busy, 1'b1);
    queue_tx(8'h96);
    send_byte(8'hA1, ack);
    chk1("rs_readdr_ack", ack, 1'b1);
    recv_byte(b, 1'b0);
    chk8("rs_rd_byte", b, tx_exp_q.pop_front());
    i2c_stop();
    drain_rx("rs");

    // asynchronous reset while driving a 0 bit in TX_DATA
    queue_tx(8'h00);
    i2c_start();
    send_byte(8'hA1, ack);
    chk1("rst_addr_ack", ack, 1'b1);
    chk8("rst_state_tx", 8'(state), 8'd5);
    chk1("rst_sda_driven", sda_oe, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk1("rst_async_release", sda_oe, 1'b0);
    wait_clk(2);
    check_reset_values("rst_mid");
    tx_exp_q.delete();
    rst_n = 1'b1;
    wait_clk(4);
    scl_m = 1'b1;
    wait_clk(8);
    exp_q.push_back(8'h3C);
    i2c_start();
    send_byte(8'hA0, ack);
    chk1("post_rst_addr_ack", ack, 1'b1);
    send_byte(8'h3C, ack);
    chk1("post_rst_data_ack", ack, 1'b1);
    i2c_stop();
    chk1("post_rst_busy", busy, 1'b0);
    drain_rx("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/i2c_target_fsm.md
# i2c_target_fsm

I2C target (slave) controller for the I2C bus that our master FSM drives. It oversamples SCL/SDA on the system clock and detects START, repeated START and STOP. It matches a 7-bit address, ACKs it, then either receives bytes (write) or transmits bytes (read) through a simple byte-level user handshake. The SDA pad is open-drain: the block only ever pulls SDA low or releases it.

## Interface
- ADDR_LEN, 7, target address width
- DATA_LEN, 8, data byte width
- TARGET_ADDR, 7'h50, address this target responds to
- clk  in  1  system clock; SCL low and high phases must each be ≥ 6 clk
- rst_n  in  1  asynchronous, active-low reset
- scl_in  in  1  raw SCL pad input, asynchronous
- sda_in  in  1  raw SDA pad input, asynchronous
- sda_oe  out  1  1 = pull SDA low; 0 = release (pad tri-stated externally)
- tx_data  in  DATA_LEN  byte to send on a read; sampled when a byte is loaded
- tx_req  out  1  one-clk pulse: tx_data is consumed at the next SCL fall
- rx_ready  in  1  1 = ACK the received byte; 0 = NACK it
- rx_data  out  DATA_LEN  last received byte
- rx_valid  out  1  one-clk pulse when rx_data updates
- addr_hit  out  1  high from address ACK until STOP or START
- busy  out  1  high from START until STOP
- state  out  3  current FSM state, for debug

## Operation
- **Input sync and edge detection**
  - scl_in and sda_in each pass through a 2-flop synchronizer. A third register holds the previous value.
  - scl_rise/scl_fall: the previous and current synchronized SCL values differ.
  - START: SDA falls while SCL is high in both the previous and current sample. STOP: SDA rises under the same condition.
  - Priority order: START/STOP, then scl_rise/scl_fall.
- **States**: IDLE=0, ADDR=1, ADDR_ACK=2, RX_DATA=3, RX_ACK=4, TX_DATA=5, TX_ACK=6. A 4-bit bit_cnt counts 0..8.
- **From any state**
  - START → ADDR. Set busy=1, bit_cnt=0, sda_oe=0, addr_hit=0.
  - STOP → IDLE. Set busy=0, sda_oe=0, addr_hit=0.
- **IDLE**: ignore SCL edges.
- **ADDR**
  - On each scl_rise, shift SDA into shift_reg MSB-first and increment bit_cnt.
  - At the scl_fall with bit_cnt==8: if shift_reg[7:1]==TARGET_ADDR, go to ADDR_ACK with sda_oe=1 and addr_hit=1. Otherwise go to IDLE.
- **ADDR_ACK**
  - If R/W (shift_reg[0])=1, pulse tx_req at the ACK scl_rise.
  - At the next scl_fall, set bit_cnt=0. If R/W=0, go to RX_DATA with sda_oe=0. If R/W=1, go to TX_DATA: load tx_data into shift_reg and set sda_oe = ~tx_data[DATA_LEN-1].
- **RX_DATA**
  - On scl_rise, shift in a bit and increment bit_cnt.
  - On the 8th rise, rx_data ← the full byte and rx_valid pulses in the next clk.
  - At the next scl_fall, go to RX_ACK with sda_oe=rx_ready.
- **RX_ACK**
  - At scl_fall: if the target ACKed, go to RX_DATA with sda_oe=0 and bit_cnt=0.
  - If the target NACKed, go to IDLE.
- **TX_DATA**
  - On scl_rise, increment bit_cnt.
  - On scl_fall with bit_cnt<8, shift left and set sda_oe = ~next MSB.
  - On scl_fall with bit_cnt==8, set sda_oe=0 and go to TX_ACK.
- **TX_ACK**
  - At scl_rise, sample SDA. SDA=0 means ACK: pulse tx_req. SDA=1 means NACK.
  - At scl_fall after an ACK: load tx_data, drive its MSB, set bit_cnt=0, go to TX_DATA.
  - At scl_fall after a NACK: set sda_oe=0 and go to IDLE.

## Timing
- **Reset values**: sda_oe=0, tx_req=0, rx_data=0, rx_valid=0, addr_hit=0, busy=0, state=IDLE, shift_reg=0, bit_cnt=0.
- Reset mid-transfer releases SDA immediately, because reset is asynchronous.
- **Pad to internal event**: 3 clk from a pad edge to the detected edge (2 sync flops plus the edge register).
- **sda_oe update**: sda_oe changes in the clk after a detected scl_fall, at most 4 clk after the pad SCL falls.
- **Setup margin**: with SCL low ≥ 6 clk, SDA is stable at least 2 clk before SCL rises.
- **tx_data timing**: tx_data must be valid from the tx_req pulse until the following SCL fall.
- **Repeated START**: START in ADDR_ACK, RX_*, or TX_* aborts the current byte without emitting rx_valid. sda_oe is released in the same clk.
- **STOP mid-byte**: STOP discards the partial byte and emits no rx_valid.
- **Tolerated pad behaviour**: SDA changing while SCL is low never triggers START/STOP. SCL and SDA changing in the same clk count as an SCL edge only.

## Test plan
- Write 0xA0 then bytes 0x3C and 0xC3, rx_ready=1, then STOP → address ACK (SDA low on 9th clock). rx_valid pulses twice with rx_data 0x3C then 0xC3. Each byte is ACKed. busy falls after STOP.
- Address 0x52 with W (byte 0xA4) → no ACK, sda_oe stays 0, addr_hit=0, the following data is ignored.
- Read 0xA1, tx_data=0xA5 then 0x5A; master ACKs the first byte and NACKs the second → SDA bits 10100101 then 01011010. tx_req pulses twice. sda_oe=0 after the NACK.
- Write 0xA0, byte 0x11 with rx_ready=0 → NACK on the 9th clock, FSM goes to IDLE, the next byte is ignored.
- Write 0xA0, 4 data bits, then repeated START and read 0xA1 → no rx_valid for the partial byte. Address re-ACKed, TX starts with tx_data.
- Assert rst_n=0 during TX_DATA while driving a 0 bit → sda_oe=0 asynchronously. All outputs reach reset values. The next START is handled normally.
